serial_adder: RTL

Bit-serial N-bit adder: captures two operands and a carry-in on `start`, adds them LSB-first one bit per clock through a single full-adder cell and carry flip-flop, then presents the registered sum and carry-out with a one-cycle `done` pulse. It is the addition counterpart of the team's borrow-chain full subtractor. Subtraction is obtained by feeding `~b` with `cin=1`; a `cout` of 1 then means "no borrow". It serves area-constrained datapaths where a WIDTH-cycle latency is acceptable.

---
 rtl/serial_adder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial WIDTH-bit adder. On an accepted start the
//                operands and carry-in are captured, then added LSB-first one
//                bit per clock through a single full-adder cell and a carry
//                flip-flop. After WIDTH cycles the registered sum and
//                carry-out are updated and done pulses for one cycle.
//                Subtraction: drive b with ~b and cin=1; cout=1 means
//                "no borrow".
//  Ports       : clk   - sole clock, rising edge
//                rst   - synchronous active-high reset
//                start - request, sampled only while idle
//                a, b  - WIDTH-bit operands, captured on accept
//                cin   - carry-in, captured on accept
//                busy  - addition in progress
//                done  - one-cycle result-valid pulse
//                sum   - result, holds until the next completion
//                cout  - final carry, holds until the next completion
//                ovf   - signed overflow (only with SERIAL_ADDER_OVF_EN)
//  Options     : define SERIAL_ADDER_OVF_EN to add the ovf output.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [0:0]       c_IDLE = 1'b0;
    localparam logic [0:0]       c_RUN  = 1'b1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_done;

    logic             w_s;
    logic             w_c_next;
    logic             w_last;

    // Single full-adder cell working on the current LSBs.
    assign w_s      = r_a[0] ^ r_b[0] ^ r_c;
    assign w_c_next = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
    assign w_last   = (r_state == c_RUN) && (r_cnt == c_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (start)  w_state_next = c_RUN;
            c_RUN:   if (w_last) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == c_IDLE) begin
                if (start) begin
                    r_a   <= a;
                    r_b   <= b;
                    r_c   <= cin;
                    r_cnt <= '0;
                end
            end else begin
                r_a   <= {1'b0, r_a[WIDTH-1:1]};
                r_b   <= {1'b0, r_b[WIDTH-1:1]};
                // Result bits enter at the MSB so that after WIDTH shifts
                // bit 0 of the sum sits at bit 0 of the register.
                r_res <= {w_s, r_res[WIDTH-1:1]};
                r_c   <= w_c_next;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_sum  <= {w_s, r_res[WIDTH-1:1]};
                    r_cout <= w_c_next;
                    r_done <= 1'b1;
                end
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // On the last bit r_c is the carry into the MSB, w_c_next the carry out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_c ^ w_c_next;
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = (r_state == c_RUN);
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire
